// File: rtl/nco_config_master_pkg.sv
// Shared encodings for the NCO configuration master: FSM states,
// command-word update bits and the default ACK/Done timeout.
package nco_config_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_SEND_FREQ = 3'd2,
    ST_SEND_PHA  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  localparam int unsigned UPD_FREQ = 0;
  localparam int unsigned UPD_PHA  = 1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/nco_config_master.sv
// Configuration master: sends a command word, then the selected frequency and
// phase words to the NCO receiver, each handshaked by ACK, then waits for Done.
module nco_config_master
  import nco_config_master_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TO_WIDTH       = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    start,
  input  logic [1:0]              upd_ctl,
  input  logic [CONFIG_WIDTH-1:0] freq_word,
  input  logic [CONFIG_WIDTH-1:0] pha_word,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    err_pulse,
  output logic                    isConfig,
  output logic [CONFIG_WIDTH-1:0] Data_Config_In,
  input  logic                    isConfigACK,
  input  logic                    isConfigDone
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [1:0]              upd_q, upd_d;
  logic [CONFIG_WIDTH-1:0] freq_q, freq_d;
  logic [CONFIG_WIDTH-1:0] pha_q, pha_d;
  logic [TO_WIDTH-1:0]     cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    cfg_q, cfg_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [CONFIG_WIDTH-1:0] data_q, data_d;
  logic                    hold;

  always_comb begin
    state_d = state_q;
    upd_d   = upd_q;
    freq_d  = freq_q;
    pha_d   = pha_q;
    cnt_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    hold    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (upd_ctl != 2'b00) begin
            upd_d   = upd_ctl;
            freq_d  = freq_word;
            pha_d   = pha_word;
            state_d = ST_SEND_CMD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SEND_CMD: begin
        if (isConfigACK) state_d = upd_q[UPD_FREQ] ? ST_SEND_FREQ : ST_SEND_PHA;
        else             hold    = 1'b1;
      end
      ST_SEND_FREQ: begin
        if (isConfigACK) begin
          if (upd_q[UPD_PHA]) begin
            state_d = ST_SEND_PHA;
          end else if (isConfigDone) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end else begin
          hold = 1'b1;
        end
      end
      ST_SEND_PHA: begin
        if (isConfigACK) begin
          if (isConfigDone) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end else begin
          hold = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (isConfigDone) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          hold = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Any state still waiting on its pulse shares one timeout path.
    if (hold) begin
      if (cnt_q == TO_LAST) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + TO_WIDTH'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    data_d = '0;
    case (state_d)
      ST_SEND_CMD:  data_d[1:0] = upd_d;
      ST_SEND_FREQ: data_d      = freq_d;
      ST_SEND_PHA:  data_d      = pha_d;
      default:      data_d      = '0;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);
  assign cfg_d  = (state_d != ST_IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      upd_q   <= '0;
      freq_q  <= '0;
      pha_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      cfg_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      upd_q   <= upd_d;
      freq_q  <= freq_d;
      pha_q   <= pha_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign busy           = busy_q;
  assign isConfig       = cfg_q;
  assign done_pulse     = done_q;
  assign err_pulse      = err_q;
  assign Data_Config_In = data_q;

endmodule

// File: doc/nco_config_master.md
NCO_CONFIG_MASTER -- requirements
Module: nco_config_master

Interface
REQ-001 Parameter CONFIG_WIDTH, 32, width of the configuration data word.
REQ-002 Parameter TIMEOUT_CYCLES, 1024, maximum cycles to wait for any ACK or Done before aborting.
REQ-003 Parameter TO_WIDTH, 16, width of the timeout counter; it SHALL hold TIMEOUT_CYCLES.
REQ-004 CLK  in  1  clock; reset nRST, asynchronous, active-low; clock CLK.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle request to run one configuration transaction.
REQ-007 upd_ctl  in  2  bit0 = send frequency word, bit1 = send phase word.
REQ-008 freq_word  in  CONFIG_WIDTH  frequency increment to transmit.
REQ-009 pha_word  in  CONFIG_WIDTH  phase offset to transmit.
REQ-010 busy  out  1  high while a transaction is in progress.
REQ-011 done_pulse  out  1  one-cycle pulse on successful completion.
REQ-012 err_pulse  out  1  one-cycle pulse on timeout abort.
REQ-013 isConfig  out  1  configuration session request to the NCO configuration receiver.
REQ-014 Data_Config_In  out  CONFIG_WIDTH  word presented to the receiver.
REQ-015 isConfigACK  in  1  receiver accepted the current word (single-cycle pulse).
REQ-016 isConfigDone  in  1  receiver applied the configuration (single-cycle pulse).

Function
REQ-017 States: IDLE, SEND_CMD, SEND_FREQ, SEND_PHA, WAIT_DONE; encoding is binary, 3 bits.
REQ-018 In IDLE, start=1 with upd_ctl!=0 SHALL latch upd_ctl, freq_word and pha_word, then enter SEND_CMD on the next edge.
REQ-019 Latency: start sampled high at edge N SHALL drive isConfig=1 and Data_Config_In = command word from cycle N+1.
REQ-020 The command word SHALL be {zeros[CONFIG_WIDTH-1:2], upd_ctl_latched}.
REQ-021 In IDLE, start=1 with upd_ctl==0 SHALL raise done_pulse in the next cycle without asserting isConfig.
REQ-022 start while busy=1 SHALL be ignored, and the latched words SHALL stay unchanged.
REQ-023 In each SEND_* state, isConfig=1 and Data_Config_In SHALL hold that state's word until isConfigACK is sampled high.
REQ-024 On ACK in SEND_CMD, the next state SHALL be:
  - SEND_FREQ if bit0 is set;
  - else SEND_PHA if bit1 is set.
REQ-025 On ACK in SEND_FREQ, the next state SHALL be SEND_PHA if bit1 is set, else WAIT_DONE.
REQ-026 On ACK in SEND_PHA, the next state SHALL be WAIT_DONE.
REQ-027 In WAIT_DONE, isConfig SHALL stay 1 and Data_Config_In SHALL be 0.
REQ-028 isConfigDone sampled high in WAIT_DONE SHALL, at the next edge:
  - return the FSM to IDLE;
  - deassert isConfig;
  - raise done_pulse for one cycle.
REQ-029 isConfigACK and isConfigDone high together in the last SEND_* state SHALL complete directly to IDLE with done_pulse, skipping WAIT_DONE.
REQ-030 isConfigDone outside WAIT_DONE (other than per REQ-029) and isConfigACK in IDLE/WAIT_DONE SHALL be ignored.
REQ-031 The timeout counter SHALL clear on start, on every accepted ACK, and in IDLE, and increment each cycle otherwise.
REQ-032 When the counter reaches TIMEOUT_CYCLES-1 without the awaited pulse, the next edge SHALL:
  - go to IDLE;
  - clear isConfig and Data_Config_In;
  - raise err_pulse for one cycle.
REQ-033 busy SHALL equal (state != IDLE); done_pulse and err_pulse SHALL never be high together.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 Asserting nRST SHALL, at any time including mid-transaction, force:
  - state IDLE;
  - isConfig, Data_Config_In, busy, done_pulse, err_pulse and the timeout counter to 0;
  - the latched registers to 0.
REQ-036 The first start SHALL be accepted on the first rising edge after nRST deasserts.

Structure
REQ-037 A shared package SHALL hold the state encoding constants, command-word bit positions (UPD_FREQ=0, UPD_PHA=1) and the default TIMEOUT_CYCLES.
REQ-038 The block SHALL be a single module; the timeout counter is inline, with no sub-module.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
  - start, upd_ctl=3, freq=0x0CCCCCCC, pha=0x40000000, ACK 2 cycles after each word, Done 3 cycles later -> words 0x3, 0x0CCCCCCC, 0x40000000 in order; done_pulse once; busy low after.
  - upd_ctl=2 -> words 0x2 then pha only; no frequency word on the bus.
  - upd_ctl=0 -> done_pulse one cycle after start; isConfig never high.
  - no ACK, TIMEOUT_CYCLES=16 -> err_pulse 16 cycles after SEND_CMD entry; isConfig=0; second start accepted.
  - ACK and Done in the same cycle on the last word -> immediate done_pulse; start during busy ignored.
  - nRST asserted in SEND_FREQ -> all outputs 0 asynchronously; no done_pulse or err_pulse.
